// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch toggle bank.
// Edge-mode encodings and the debounce counter width function.
package switch_pkg;

  localparam logic [1:0] EDGE_RELEASE = 2'd0;
  localparam logic [1:0] EDGE_PRESS   = 2'd1;
  localparam logic [1:0] EDGE_BOTH    = 2'd2;

  // Counter must be able to represent DEBOUNCE_LIMIT-1; one extra bit of headroom is harmless.
  function automatic int db_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_chan.sv
// One switch channel: 2-flop synchroniser, debounce counter and stable level.
// o_Accept strobes combinationally on the cycle whose clock edge updates the stable level.
module switch_debounce_chan
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Stable,
  output logic o_Accept,
  output logic o_New_Level
);

  localparam int CW = db_cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_LIMIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_sync2 != r_stable) && (r_cnt == LAST_CNT);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_Switch;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_Stable    = r_stable;
  assign o_Accept    = w_accept;
  assign o_New_Level = r_sync2;

endmodule

// File: rtl/switch_toggle_bank.sv
// N-channel debounced switch-to-LED toggle controller.
// Optional registered per-channel edge strobe when SWITCH_TOGGLE_PULSE_EN is defined.
module switch_toggle_bank
  import switch_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int EDGE_MODE      = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Switch_Db
`ifdef SWITCH_TOGGLE_PULSE_EN
  ,
  output logic [NUM_CH-1:0] o_Edge_Pulse
`endif
);

  localparam logic [1:0] L_MODE = EDGE_MODE[1:0];

  generate
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
      $error("switch_toggle_bank: EDGE_MODE must be 0, 1 or 2");
    end
    if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
      $error("switch_toggle_bank: DEBOUNCE_LIMIT must be >= 1");
    end
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
      $error("switch_toggle_bank: NUM_CH must be within 1..32");
    end
  endgenerate

  logic [NUM_CH-1:0] w_stable;
  logic [NUM_CH-1:0] w_accept;
  logic [NUM_CH-1:0] w_new_level;
  logic [NUM_CH-1:0] w_qual;
  logic [NUM_CH-1:0] r_led;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      switch_debounce_chan #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
      ) u_chan (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Switch   (i_Switch[gi]),
        .o_Stable   (w_stable[gi]),
        .o_Accept   (w_accept[gi]),
        .o_New_Level(w_new_level[gi])
      );

      // The new level is the synchronised sample being accepted this cycle.
      assign w_qual[gi] = w_accept[gi] &
                          ((L_MODE == EDGE_BOTH)  ? 1'b1 :
                           (L_MODE == EDGE_PRESS) ? w_new_level[gi] : ~w_new_level[gi]);
    end
  endgenerate

  // Clear wins over any toggle landing on the same edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_led <= '0;
    end else if (i_Clear) begin
      r_led <= '0;
    end else begin
      r_led <= r_led ^ w_qual;
    end
  end

  assign o_LED       = r_led;
  assign o_Switch_Db = w_stable;

`ifdef SWITCH_TOGGLE_PULSE_EN
  logic [NUM_CH-1:0] r_pulse;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_qual;
    end
  end

  assign o_Edge_Pulse = r_pulse;
`endif

endmodule
